fcnn_seq_ctrl: RTL

Time-multiplexed sequencer for the fixed 2-4-2-2 perceptron network. It evaluates all eight neurons one after another on a single shared multiply/divide/accumulate unit and one piecewise-linear sigmoid unit, reading weights from an internal run-time-loadable weight register file. Its results are bit-exact with the fully combinational network given the same weights. It sits between an upstream sample source and a downstream consumer, with valid/ready handshakes on both sides.

---
 rtl/fcnn_seq_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fcnn_seq_ctrl.sv
// fcnn_seq_ctrl: time-multiplexed sequencer for a fixed 2-4-2-2 perceptron network.
// All eight neurons are evaluated one after another on one shared multiply/divide/
// accumulate datapath and one piecewise-linear sigmoid. Weights live in a run-time
// loadable register file that may only be written while idle.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     sample handshake; in_ready is high only in IDLE
//   in0, in1              signed network inputs (SCALE represents 1.0)
//   out_valid/out_ready   result handshake; result held while out_ready is low
//   out0, out1            signed network outputs (500..1000), hold last result
//   cfg_we/addr/data      weight write port
//   cfg_drop              sticky: some weight write was discarded (cleared by rst)
//   busy                  high whenever the sequencer is not idle
module fcnn_seq_ctrl #(
   parameter int unsigned NW    = 20,
   parameter int unsigned SCALE = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] in0,
   input  logic signed [15:0] in1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out0,
   output logic signed [15:0] out1,
   input  logic               cfg_we,
   input  logic        [4:0]  cfg_addr,
   input  logic signed [15:0] cfg_data,
   output logic               cfg_drop,
   output logic               busy
);

   localparam logic        [4:0]  NwAddr = 5'(NW);
   localparam logic signed [31:0] ScaleS = 32'(SCALE);
   localparam logic        [31:0] ScaleU = 32'(SCALE);

   typedef enum logic [1:0] {StIdle, StMac, StAct, StDone} state_e;

   state_e state_q, state_d;

   logic        [1:0]  layer_q;
   logic        [1:0]  neuron_q;
   logic        [1:0]  term_q;
   logic signed [31:0] acc_q;
   logic signed [15:0] out0_q, out1_q;
   logic               drop_q;

   // Activation buffer: [0:1] inputs, [2:5] layer 0, [6:7] layer 1, [8:9] layer 2.
   logic signed [15:0] act_q [10];
   logic signed [15:0] w_q   [NW];

   logic               last_term, last_neuron, last_layer;
   logic        [4:0]  w_addr;
   logic        [3:0]  src_idx, dst_idx;
   logic signed [15:0] a_sel, w_sel;
   logic signed [31:0] prod, term;
   logic        [31:0] ax;
   logic signed [15:0] y;
   logic               w_ok;

   // Per-layer addressing: weight base/fan-in, source and destination buffer slots.
   always_comb begin
      last_term   = 1'b0;
      last_neuron = 1'b0;
      w_addr      = '0;
      src_idx     = '0;
      dst_idx     = '0;
      case (layer_q)
         2'd0: begin
            last_term   = (term_q == 2'd1);
            last_neuron = (neuron_q == 2'd3);
            w_addr      = {2'b00, neuron_q, term_q[0]};
            src_idx     = {3'b000, term_q[0]};
            dst_idx     = 4'd2 + {2'b00, neuron_q};
         end
         2'd1: begin
            last_term   = (term_q == 2'd3);
            last_neuron = (neuron_q == 2'd1);
            w_addr      = 5'd8 + {2'b00, neuron_q[0], term_q};
            src_idx     = 4'd2 + {2'b00, term_q};
            dst_idx     = 4'd6 + {3'b000, neuron_q[0]};
         end
         default: begin
            last_term   = (term_q == 2'd1);
            last_neuron = (neuron_q == 2'd1);
            w_addr      = 5'd16 + {3'b000, neuron_q[0], term_q[0]};
            src_idx     = 4'd6 + {3'b000, term_q[0]};
            dst_idx     = 4'd8 + {3'b000, neuron_q[0]};
         end
      endcase
   end

   assign last_layer = (layer_q == 2'd2);

   // Shared MAC term: full 32-bit signed product, scaled per term (truncates toward zero).
   always_comb begin
      a_sel = act_q[src_idx];
      w_sel = w_q[w_addr];
      prod  = $signed({{16{a_sel[15]}}, a_sel}) * $signed({{16{w_sel[15]}}, w_sel});
      term  = prod / ScaleS;
   end

   // Piecewise-linear sigmoid on |acc|; even in acc by construction.
   always_comb begin
      ax = acc_q[31] ? 32'(-acc_q) : 32'(acc_q);
      if (ax >= 32'd5000) begin
         y = 16'sd1000;
      end else if (ax >= 32'd2375) begin
         y = 16'((32'd31 * ax) / ScaleU + 32'd844);
      end else if (ax >= 32'd1000) begin
         y = 16'((32'd125 * ax) / ScaleU + 32'd625);
      end else begin
         y = 16'((32'd250 * ax) / ScaleU + 32'd500);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_valid) state_d = StMac;
         StMac:   if (last_term) state_d = StAct;
         StAct:   state_d = (last_layer && last_neuron) ? StDone : StMac;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // A weight write lands only while idle and in range; anything else is flagged.
   assign w_ok = cfg_we && (state_q == StIdle) && (cfg_addr < NwAddr);

   always_ff @(posedge clk) begin
      if (rst) begin
         layer_q  <= '0;
         neuron_q <= '0;
         term_q   <= '0;
         acc_q    <= '0;
         out0_q   <= '0;
         out1_q   <= '0;
         drop_q   <= 1'b0;
         for (int i = 0; i < 10; i++) act_q[i] <= '0;
         for (int i = 0; i < int'(NW); i++) w_q[i] <= '0;
      end else begin
         if (w_ok) begin
            w_q[cfg_addr] <= cfg_data;
         end
         if (cfg_we && !w_ok) begin
            drop_q <= 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  act_q[0] <= in0;
                  act_q[1] <= in1;
                  acc_q    <= '0;
                  layer_q  <= '0;
                  neuron_q <= '0;
                  term_q   <= '0;
               end
            end
            StMac: begin
               acc_q  <= acc_q + term;
               term_q <= last_term ? 2'd0 : term_q + 2'd1;
            end
            StAct: begin
               act_q[dst_idx] <= y;
               acc_q          <= '0;
               if (last_neuron) begin
                  neuron_q <= '0;
                  if (last_layer) begin
                     layer_q <= '0;
                     // Neuron 0 of layer 2 is already in the buffer; neuron 1 is y.
                     out0_q  <= act_q[8];
                     out1_q  <= y;
                  end else begin
                     layer_q <= layer_q + 2'd1;
                  end
               end else begin
                  neuron_q <= neuron_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign out0      = out0_q;
   assign out1      = out1_q;
   assign cfg_drop  = drop_q;

endmodule
